// File: rtl/serial_mult_pkg.sv
// Shared types and helpers for the bit-serial shift-add multiplier.
package serial_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned WIDTH_DEFAULT = 8;

  // Width of the bit/iteration counters; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_mult_ctrl_fa_cell.sv
// One-bit full adder: res = {cout, sum} = x + y + z.
module fa_cell (
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic [1:0] res
);

  // Majority for carry, parity for sum.
  always_comb begin
    res = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  end

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial unsigned shift-add multiplier controller.
// A single full-adder cell is sequenced over the accumulator, one bit per
// cycle, to form a WIDTH x WIDTH -> 2*WIDTH product.
// Optional build macro SERIAL_MULT_SKIP_ZERO_EN: iterations whose multiplier
// bit is zero bypass the ADD phase and go straight to SHIFT.
module serial_mult_ctrl
  import serial_mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 c_q, c_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]        iter_cnt_q, iter_cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [1:0]           fa_res;

  // The only adder in the datapath: accumulator LSB + gated multiplicand LSB + carry.
  fa_cell u_fa (
    .x   (a_q[0]),
    .y   (m_q[0] & q_q[0]),
    .z   (c_q),
    .res (fa_res)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      a_q        <= '0;
      q_q        <= '0;
      c_q        <= 1'b0;
      bit_cnt_q  <= '0;
      iter_cnt_q <= '0;
      product_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      a_q        <= a_d;
      q_q        <= q_d;
      c_q        <= c_d;
      bit_cnt_q  <= bit_cnt_d;
      iter_cnt_q <= iter_cnt_d;
      product_q  <= product_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    a_d        = a_q;
    q_d        = q_q;
    c_d        = c_q;
    bit_cnt_d  = bit_cnt_q;
    iter_cnt_d = iter_cnt_q;
    product_d  = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d        = a;
          q_d        = b;
          a_d        = '0;
          c_d        = 1'b0;
          bit_cnt_d  = '0;
          iter_cnt_d = '0;
          state_d    = ADD;
`ifdef SERIAL_MULT_SKIP_ZERO_EN
          if (!b[0]) state_d = SHIFT;
`endif
        end
      end
      ADD: begin
        // A and M rotate together so after WIDTH cycles both are realigned.
        a_d = {fa_res[0], a_q[WIDTH-1:1]};
        m_d = {m_q[0], m_q[WIDTH-1:1]};
        c_d = fa_res[1];
        if (bit_cnt_q == LAST) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // Pending carry becomes the new accumulator MSB.
        a_d = {c_q, a_q[WIDTH-1:1]};
        q_d = {a_q[0], q_q[WIDTH-1:1]};
        c_d = 1'b0;
        if (iter_cnt_q == LAST) begin
          product_d = {a_d, q_d};
          state_d   = DONE;
        end else begin
          iter_cnt_d = iter_cnt_q + 1'b1;
          state_d    = ADD;
`ifdef SERIAL_MULT_SKIP_ZERO_EN
          // q_q[1] is the multiplier bit that will sit in Q[0] next iteration.
          if (!q_q[1]) state_d = SHIFT;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == ADD) || (state_q == SHIFT);
    product   = product_q;
  end

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Self-checking bench for serial_mult_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];

  serial_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  serial_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  function automatic int exp_lat(input int w, input int bv);
`ifdef SERIAL_MULT_SKIP_ZERO_EN
    return w + w * $countones(bv);
`else
    return w * (w + 1) + 0 * bv;
`endif
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0;
    in_valid4 = 0; out_ready4 = 1; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
    checks++;
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    checks++;
    if (product8 !== 16'd0) begin errors++; $display("FAIL reset_product got %0d want 0", product8); end
    checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100) begin
      errors++; $display("FAIL reset_w4_status got %b want 100", {in_ready4, out_valid4, busy4});
    end
    checks++;
  endtask

  // One WIDTH=8 transaction with optional back-pressure of 'hold' cycles.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int hold);
    int lat, busy_n, bad_ready, want_lat;
    logic [15:0] got, want;
    @(negedge clk);
    lat = 0;
    while (!in_ready8 && lat < 200) begin @(negedge clk); lat++; end
    if (in_ready8 !== 1'b1) begin errors++; $display("FAIL accept_wait got in_ready=%b want 1", in_ready8); end
    checks++;
    a8 = av; b8 = bv; in_valid8 = 1'b1;
    sb8.push_back(16'(av) * 16'(bv));
    want_lat = exp_lat(8, int'(bv));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = ~av; b8 = ~bv;
    lat = 0; busy_n = 0; bad_ready = 0;
    while (!out_valid8 && lat < 2000) begin
      if (busy8) busy_n++;
      if (in_ready8) bad_ready++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (lat !== want_lat) begin errors++; $display("FAIL latency8 a=%0d b=%0d got %0d want %0d", av, bv, lat, want_lat); end
    checks++;
    if (busy_n !== want_lat) begin errors++; $display("FAIL busy_cycles8 got %0d want %0d", busy_n, want_lat); end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL in_ready_while_busy got %0d want 0", bad_ready); end
    checks++;
    got = product8;
    in_valid8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if ({out_valid8, in_ready8, product8} !== {2'b10, got}) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b p=%0d want v=1 r=0 p=%0d",
                 i, out_valid8, in_ready8, product8, got);
      end
      checks++;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready8 = 1'b0;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++; $display("FAIL return_idle got v=%b r=%b want v=0 r=1", out_valid8, in_ready8);
    end
    checks++;
    if (sb8.size() > 0) begin
      want = sb8.pop_front();
      if (got !== want) begin errors++; $display("FAIL product8 a=%0d b=%0d got %0d want %0d", av, bv, got, want); end
    end else begin
      errors++; $display("FAIL scoreboard8 got empty want entry");
    end
    checks++;
  endtask

  // One WIDTH=4 transaction; out_ready is held high.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv);
    int lat;
    logic [7:0] want;
    @(negedge clk);
    lat = 0;
    while (!in_ready4 && lat < 100) begin @(negedge clk); lat++; end
    a4 = av; b4 = bv; in_valid4 = 1'b1;
    sb4.push_back(8'(av) * 8'(bv));
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 500) begin @(posedge clk); lat++; @(negedge clk); end
    if (lat !== exp_lat(4, int'(bv))) begin
      errors++; $display("FAIL latency4 a=%0d b=%0d got %0d want %0d", av, bv, lat, exp_lat(4, int'(bv)));
    end
    checks++;
    want = (sb4.size() > 0) ? sb4.pop_front() : 8'hxx;
    if (product4 !== want) begin errors++; $display("FAIL product4 a=%0d b=%0d got %0d want %0d", av, bv, product4, want); end
    checks++;
  endtask

  task automatic test_basic();
    run8(8'd13, 8'd11, 0);
    run8(8'd255, 8'd255, 0);
    run8(8'd0, 8'd200, 0);
    run8(8'd77, 8'd0, 0);
  endtask

  task automatic test_back_pressure();
    run8(8'd7, 8'd9, 10);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd3; in_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid8 = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if ({out_valid8, in_ready8, busy8} !== 3'b010) begin
      errors++; $display("FAIL abort_status got v=%b r=%b busy=%b want v=0 r=1 busy=0", out_valid8, in_ready8, busy8);
    end
    checks++;
    if (product8 !== 16'd0) begin errors++; $display("FAIL abort_product got %0d want 0", product8); end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    run8(8'd5, 8'd6, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) run8(8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 500; i++) run4(4'($urandom), 4'($urandom));
    run4(4'd15, 4'd15);
    run4(4'd0, 4'd9);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mult_ctrl.md
Name: serial_mult_ctrl

Overview:
- Bit-serial unsigned shift-add multiplier controller.
- Sequences a single one-bit full-adder cell over the accumulator to form a WIDTH x WIDTH -> 2*WIDTH product.
- Sits in the multiplier datapath as the minimum-area alternative to the array multiplier.
- Uses a valid/ready handshake on both operand input and product output.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid (high only in DONE).
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, held stable while out_valid is high.
- busy  output  1  high in ADD or SHIFT.

Behaviour:
- Reset (asynchronous, active-high, clk/rst as named above):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; product=0.
  - Internal A, M, Q, carry and counters are cleared to 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- Registers:
  - M: WIDTH bits, multiplicand.
  - A: WIDTH bits, accumulator high half.
  - Q: WIDTH bits, multiplier, becoming the product low half.
  - c: 1-bit carry.
  - bit_cnt and iter_cnt: each $clog2(WIDTH) bits.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: M<=a, Q<=b, A<=0, c<=0, bit_cnt<=0, iter_cnt<=0, go to ADD.
- ADD (one adder bit per cycle):
  - {cout,sum} = fa_cell(A[0], M[0]&Q[0], c).
  - A<={sum,A[WIDTH-1:1]}, M<={M[0],M[WIDTH-1:1]}, c<=cout.
  - When bit_cnt==WIDTH-1: bit_cnt<=0 and go to SHIFT. Otherwise bit_cnt++.
  - After WIDTH cycles A and M are back in their original bit alignment.
- SHIFT (one cycle):
  - A<={c,A[WIDTH-1:1]}, Q<={A[0],Q[WIDTH-1:1]}, c<=0.
  - When iter_cnt==WIDTH-1: product<={new A,new Q} and go to DONE. Otherwise iter_cnt++ and go to ADD.
- DONE:
  - out_valid=1.
  - On out_ready: out_valid drops next cycle and the block returns to IDLE.
  - Otherwise it holds indefinitely; product stays stable.
- Operands arriving during ADD, SHIFT or DONE are not accepted (in_ready=0).
- No back-to-back overlap: there is at least one IDLE cycle between results.
- Latency: out_valid rises exactly WIDTH*(WIDTH+1) cycles after the accepting edge (72 for WIDTH=8).
- Arithmetic:
  - Unsigned only; a full 2*WIDTH product, so no overflow is possible.
  - Carry out of ADD is never lost; SHIFT absorbs it into A[WIDTH-1].
- Edge cases:
  - a=0 or b=0 gives product 0 with the same latency.
  - Max operands (2^WIDTH-1)^2 must be exact.

Optional Feature:
- Macro: SERIAL_MULT_SKIP_ZERO_EN.
- Defined:
  - On entry to each iteration, if Q[0]==0 the block goes straight to SHIFT, skipping ADD.
  - Latency = WIDTH + WIDTH*popcount(b) cycles.
  - For b=0 the latency is WIDTH.
- Undefined: fixed latency WIDTH*(WIDTH+1); no skip logic is present.
- Product values are identical in both builds.

Decomposition:
- Package serial_mult_pkg contains:
  - the state enum (IDLE, ADD, SHIFT, DONE), 2-bit encoding;
  - localparam WIDTH_DEFAULT=8;
  - a counter-width constant function.
- Sub-module fa_cell:
  - combinational one-bit full adder;
  - inputs x, y, z; output 2-bit {cout,sum}=x+y+z;
  - exactly one instance, in the ADD datapath.

Test Plan:
- Reset then a=13, b=11, WIDTH=8 -> out_valid exactly 72 cycles after accept; product=143; in_ready=0 throughout; busy high for 72 cycles.
- a=255, b=255 -> product=65025; then a=0, b=200 -> product=0 with the same 72-cycle latency.
- Back-pressure: hold out_ready=0 for 10 cycles after a=7, b=9 -> product=63 stable; out_valid stays high; in_valid ignored; IDLE follows the cycle after out_ready.
- Assert rst at cycle 30 of a=100, b=3 -> out_valid=0, product=0, in_ready=1 immediately. A new a=5, b=6 then yields 30 after 72 cycles.
- Randomised 500 operand pairs at WIDTH=4 and WIDTH=8 against a reference a*b -> all products match.
- With SERIAL_MULT_SKIP_ZERO_EN: a=13, b=11 -> latency 8+8*3=32 cycles, product=143; b=0 -> latency 8, product=0.
